mem_access: RTL and testbench

Parametrised successor of the CPU memory stage. Performs one bus transaction per accepted request, with explicit valid/ready handshaking. Operations are LOAD, STORE, PUSH and POP on a big-endian byte-lane bus, with configurable data width.

---
 rtl/mem_access_pkg.sv | 41 ++++
 rtl/mem_access_lane_align.sv | 44 ++++
 rtl/mem_access.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and lane helper for the mem_access load/store/stack stage.
package mem_access_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } mem_op_t;

  typedef enum logic [2:0] {
    EXC_NONE         = 3'd0,
    EXC_MISALIGNED   = 3'd1,
    EXC_BUS_ERR      = 3'd2,
    EXC_TIMEOUT      = 3'd3,
    EXC_ILLEGAL_SIZE = 3'd4
  } exc_cause_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_BUS2,
    ST_RESP
  } state_t;

  // Big-endian lanes: the byte at offset i within an nb-byte window drives sel bit nb-1-i.
  function automatic logic [15:0] lane_sel(input logic [1:0] size, input int offset, input int nb);
    logic [15:0] sel;
    logic [3:0]  idx;
    int          n;
    sel = '0;
    n   = 1 << size;
    for (int i = 0; i < 16; i++) begin
      idx = 4'(nb - 1 - i);
      if (i < nb && i >= offset && i < offset + n) sel[idx] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// Lane steering for mem_access: shifts write data onto byte lanes and extracts/extends read data.
// WORDS=2 gives a two-word window used when misaligned accesses are split across bus words.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WORDS  = 1,
  localparam int NB     = DATA_W / 8,
  localparam int WB     = NB * WORDS,
  localparam int WW     = DATA_W * WORDS,
  localparam int WOFF_W = $clog2(WB)
) (
  input  logic [1:0]        size,
  input  logic [WOFF_W-1:0] offset,
  input  logic              signed_ld,
  input  logic [DATA_W-1:0] wdata,
  input  logic [WW-1:0]     rwin,
  output logic [WW-1:0]     wwin,
  output logic [WB-1:0]     sel,
  output logic [DATA_W-1:0] rdata
);

  logic [15:0]       sel16;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] msb;
  logic [DATA_W-1:0] raw;
  int                nbytes;
  int                shift;

  always_comb begin
    nbytes = 1 << size;
    shift  = 0;
    if (int'(offset) + nbytes <= WB) shift = (WB - int'(offset) - nbytes) * 8;
    if (nbytes * 8 >= DATA_W) mask = '1;
    else                      mask = ~({DATA_W{1'b1}} << (nbytes * 8));
    msb   = mask & ~(mask >> 1);
    sel16 = lane_sel(size, int'(offset), WB);
    sel   = sel16[WB-1:0];
    wwin  = WW'(wdata & mask) << shift;
    raw   = DATA_W'(rwin >> shift) & mask;
    rdata = (signed_ld && |(raw & msb)) ? (raw | ~mask) : raw;
  end

endmodule

// File: rtl/mem_access.sv
// CPU memory stage: one bus transaction per accepted LOAD/STORE/PUSH/POP with fault reporting.
// Build option MEM_ACCESS_UNALIGNED_SPLIT_EN splits word-crossing misaligned accesses into two bus cycles.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int NB     = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        op_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] sp_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              sp_write_o,
  output logic [ADDR_W-1:0] sp_data_o,
  output logic              exc_o,
  output logic [2:0]        exc_cause_o,
  output logic              bus_cyc_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_adr_o,
  output logic [NB-1:0]     bus_sel_o,
  output logic [DATA_W-1:0] bus_dat_o,
  input  logic [DATA_W-1:0] bus_dat_i,
  input  logic              bus_ack_i,
  input  logic              bus_err_i
);

  localparam int OFF_W = $clog2(NB);
`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
  localparam int WORDS = 2;
`else
  localparam int WORDS = 1;
`endif
  localparam int WB     = NB * WORDS;
  localparam int WW     = DATA_W * WORDS;
  localparam int WOFF_W = $clog2(WB);
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  state_t            state_q, state_d;
  mem_op_t           op_in;
  logic [ADDR_W-1:0] eff_addr, sp_upd;
  logic [1:0]        eff_size;
  logic [3:0]        nbytes;
  logic              is_mem, is_stack, we_in, illegal, fault_in, tmo;
  exc_cause_t        cause_in;

  logic [1:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic              signed_q, we_q, stack_q, cyc_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] adr_q, sp_next_q;
  logic [TMR_W-1:0]  tmr_q;

  logic [DATA_W-1:0] rdata_q;
  logic              exc_q, sp_write_q;
  exc_cause_t        cause_q;
  logic [ADDR_W-1:0] sp_data_q;

  logic [WW-1:0]     rwin, wwin;
  logic [WB-1:0]     sel_win;
  logic [NB-1:0]     lane_sel_w;
  logic [DATA_W-1:0] lane_dat_w, align_rdata;

`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
  logic              cross_in, cross_q;
  logic [DATA_W-1:0] rd_hi_q;
`endif

  assign op_in = mem_op_t'(op_i);

  always_comb begin
    eff_addr = addr_i;
    eff_size = size_i;
    sp_upd   = sp_i;
    is_mem   = 1'b0;
    is_stack = 1'b0;
    we_in    = 1'b0;
    case (op_in)
      OP_LOAD:  is_mem = 1'b1;
      OP_STORE: begin is_mem = 1'b1; we_in = 1'b1; end
      OP_PUSH: begin
        is_mem   = 1'b1;
        is_stack = 1'b1;
        we_in    = 1'b1;
        eff_addr = sp_i - ADDR_W'(NB);
        eff_size = 2'(OFF_W);
        sp_upd   = sp_i - ADDR_W'(NB);
      end
      OP_POP: begin
        is_mem   = 1'b1;
        is_stack = 1'b1;
        eff_addr = sp_i;
        eff_size = 2'(OFF_W);
        sp_upd   = sp_i + ADDR_W'(NB);
      end
      default: ;
    endcase
  end

  always_comb begin
    illegal  = is_mem && (eff_size == 2'd3) && (DATA_W == 32);
    nbytes   = 4'd1 << eff_size;
    cause_in = illegal ? EXC_ILLEGAL_SIZE : EXC_MISALIGNED;
`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
    cross_in = (int'(eff_addr[OFF_W-1:0]) + int'(nbytes)) > NB;
    fault_in = illegal;
`else
    fault_in = illegal || (is_mem && ((eff_addr[3:0] & (nbytes - 4'd1)) != 4'd0));
`endif
  end

  // Ack/err take priority over the watchdog firing in the same cycle.
  assign tmo = (TIMEOUT > 0) && (tmr_q == '0) && !bus_ack_i && !bus_err_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid_i) state_d = (is_mem && !fault_in) ? ST_BUS : ST_RESP;
      ST_BUS: begin
        if (bus_err_i || tmo) state_d = ST_RESP;
`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
        else if (bus_ack_i) state_d = cross_q ? ST_BUS2 : ST_RESP;
`else
        else if (bus_ack_i) state_d = ST_RESP;
`endif
      end
      ST_BUS2: if (bus_err_i || bus_ack_i || tmo) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      size_q     <= '0;
      off_q      <= '0;
      signed_q   <= 1'b0;
      we_q       <= 1'b0;
      stack_q    <= 1'b0;
      cyc_q      <= 1'b0;
      wdata_q    <= '0;
      adr_q      <= '0;
      sp_next_q  <= '0;
      tmr_q      <= '0;
      rdata_q    <= '0;
      exc_q      <= 1'b0;
      cause_q    <= EXC_NONE;
      sp_write_q <= 1'b0;
      sp_data_q  <= '0;
`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
      cross_q    <= 1'b0;
      rd_hi_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid_i) begin
          size_q    <= eff_size;
          off_q     <= eff_addr[OFF_W-1:0];
          signed_q  <= signed_i;
          we_q      <= we_in;
          stack_q   <= is_stack;
          wdata_q   <= wdata_i;
          adr_q     <= {eff_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
          sp_next_q <= sp_upd;
          tmr_q     <= TMR_LOAD;
`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
          cross_q   <= cross_in;
`endif
          if (is_mem && !fault_in) begin
            cyc_q <= 1'b1;
          end else begin
            exc_q      <= fault_in;
            cause_q    <= fault_in ? cause_in : EXC_NONE;
            rdata_q    <= '0;
            sp_write_q <= 1'b0;
            sp_data_q  <= '0;
          end
        end
        ST_BUS, ST_BUS2: begin
          if (bus_err_i || tmo) begin
            cyc_q      <= 1'b0;
            exc_q      <= 1'b1;
            cause_q    <= bus_err_i ? EXC_BUS_ERR : EXC_TIMEOUT;
            rdata_q    <= '0;
            sp_write_q <= 1'b0;
            sp_data_q  <= '0;
          end else if (bus_ack_i) begin
`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
            // First half of a word-crossing access: keep cyc up, move to the next word.
            if (cross_q && state_q == ST_BUS) begin
              rd_hi_q <= bus_dat_i;
              adr_q   <= adr_q + ADDR_W'(NB);
              tmr_q   <= TMR_LOAD;
            end else
`endif
            begin
              cyc_q      <= 1'b0;
              exc_q      <= 1'b0;
              cause_q    <= EXC_NONE;
              rdata_q    <= we_q ? '0 : align_rdata;
              sp_write_q <= stack_q;
              sp_data_q  <= stack_q ? sp_next_q : '0;
            end
          end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ACCESS_UNALIGNED_SPLIT_EN
  assign rwin       = cross_q ? {rd_hi_q, bus_dat_i} : {bus_dat_i, {DATA_W{1'b0}}};
  assign lane_sel_w = (state_q == ST_BUS2) ? sel_win[NB-1:0] : sel_win[WB-1:NB];
  assign lane_dat_w = (state_q == ST_BUS2) ? wwin[DATA_W-1:0] : wwin[WW-1:DATA_W];
`else
  assign rwin       = bus_dat_i;
  assign lane_sel_w = sel_win;
  assign lane_dat_w = wwin;
`endif

  mem_lane_align #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS)
  ) u_align (
    .size      (size_q),
    .offset    (WOFF_W'(off_q)),
    .signed_ld (signed_q),
    .wdata     (wdata_q),
    .rwin      (rwin),
    .wwin      (wwin),
    .sel       (sel_win),
    .rdata     (align_rdata)
  );

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rdata_o     = rdata_q;
  assign exc_o       = exc_q;
  assign exc_cause_o = cause_q;
  assign sp_write_o  = sp_write_q;
  assign sp_data_o   = sp_data_q;
  assign bus_cyc_o   = cyc_q;
  assign bus_we_o    = cyc_q && we_q;
  assign bus_adr_o   = adr_q;
  assign bus_sel_o   = cyc_q ? lane_sel_w : '0;
  assign bus_dat_o   = (cyc_q && we_q) ? lane_dat_w : '0;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access (DATA_W=32, TIMEOUT=8, split feature off) with a byte-level reference model.
module tb_mem_access;

  localparam int NB  = 4;
  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  op_i = '0;
  logic [1:0]  size_i = '0;
  logic        signed_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0, sp_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rdata_o;
  logic        sp_write_o;
  logic [31:0] sp_data_o;
  logic        exc_o;
  logic [2:0]  exc_cause_o;
  logic        bus_cyc_o, bus_we_o;
  logic [31:0] bus_adr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i = '0;
  logic        bus_ack_i = 1'b0, bus_err_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference-model expectations for the current request
  logic        e_bus, e_we, e_exc, e_spw, e_chk_rd;
  logic [31:0] e_adr, e_dat, e_rdata, e_spd;
  logic [3:0]  e_sel;
  logic [2:0]  e_cause;

  mem_access #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .size_i(size_i), .signed_i(signed_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .sp_i(sp_i),
    .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o),
    .sp_write_o(sp_write_o), .sp_data_o(sp_data_o),
    .exc_o(exc_o), .exc_cause_o(exc_cause_o),
    .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
    .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode: 0 ack, 1 err, 2 no response, 3 ack+err together
  task automatic model(input logic [2:0] op, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] sp,
                       input int mode, input logic [31:0] rdat);
    int          n, lane;
    logic [31:0] a;
    logic [63:0] val;
    logic        is_mem, is_rd, is_stk, fault, ok;
    logic [2:0]  fc;
    is_mem = (op >= 3'd1) && (op <= 3'd4);
    is_rd  = (op == 3'd1) || (op == 3'd4);
    is_stk = (op == 3'd3) || (op == 3'd4);
    n      = is_stk ? NB : (1 << size);
    a      = (op == 3'd3) ? sp - NB : ((op == 3'd4) ? sp : addr);
    fault  = 1'b0;
    fc     = 3'd0;
    if (is_mem && !is_stk && size == 2'd3) begin fault = 1'b1; fc = 3'd4; end
    else if (is_mem && (a % n) != 0)       begin fault = 1'b1; fc = 3'd1; end
    e_bus = is_mem && !fault;
    e_adr = a & ~32'(NB - 1);
    e_we  = (op == 3'd2) || (op == 3'd3);
    e_sel = '0;
    e_dat = '0;
    val   = '0;
    if (e_bus) begin
      for (int k = 0; k < n; k++) begin
        lane = NB - 1 - int'((a + k) % NB);
        e_sel[lane] = 1'b1;
        e_dat[lane*8 +: 8] = wdata[(n-1-k)*8 +: 8];
        val = (val << 8) | 64'(rdat[lane*8 +: 8]);
      end
      if (sgn && n < 8 && val[n*8-1]) val = val | ~((64'd1 << (n*8)) - 64'd1);
    end
    ok = e_bus && (mode == 0);
    if (fault)       begin e_exc = 1'b1; e_cause = fc;   end
    else if (!e_bus) begin e_exc = 1'b0; e_cause = 3'd0; end
    else if (mode == 0) begin e_exc = 1'b0; e_cause = 3'd0; end
    else if (mode == 2) begin e_exc = 1'b1; e_cause = 3'd3; end
    else begin e_exc = 1'b1; e_cause = 3'd2; end
    e_chk_rd = e_exc || (ok && is_rd);
    e_rdata  = (ok && is_rd) ? val[31:0] : 32'd0;
    e_spw    = ok && is_stk;
    e_spd    = (op == 3'd3) ? sp - NB : sp + NB;
  endtask

  task automatic do_req(input string name, input logic [2:0] op, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] sp,
                        input int mode, input int dly, input logic [31:0] rdat);
    int          t, t_rsp, cyc_cnt, unstable, ready_bad, exp_cyc, exp_t;
    logic [31:0] s_adr, s_dat;
    logic [3:0]  s_sel;
    logic        s_we;
    model(op, size, sgn, addr, wdata, sp, mode, rdat);
    @(negedge clk_i);
    check_val({name, "_ready_idle"}, req_ready_o, 1);
    req_valid_i = 1'b1; op_i = op; size_i = size; signed_i = sgn;
    addr_i = addr; wdata_i = wdata; sp_i = sp;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0; op_i = 3'd0; addr_i = $urandom; wdata_i = $urandom; sp_i = $urandom;
    t = 0; t_rsp = 0; cyc_cnt = 0; unstable = 0; ready_bad = 0;
    s_adr = '0; s_dat = '0; s_sel = '0; s_we = 1'b0;
    while (t_rsp == 0 && t < 40) begin
      @(negedge clk_i);
      t++;
      bus_ack_i = 1'b0;
      bus_err_i = 1'b0;
      if (rsp_valid_o) t_rsp = t;
      else begin
        if (req_ready_o) ready_bad++;
        if (bus_cyc_o) begin
          if (cyc_cnt == 0) begin
            s_adr = bus_adr_o; s_sel = bus_sel_o; s_we = bus_we_o; s_dat = bus_dat_o;
          end else if ({bus_adr_o, bus_sel_o, bus_we_o, bus_dat_o} !== {s_adr, s_sel, s_we, s_dat}) begin
            unstable++;
          end
          cyc_cnt++;
          if (t == dly + 1 && mode != 2) begin
            bus_ack_i = (mode != 1);
            bus_err_i = (mode != 0);
            bus_dat_i = rdat;
          end
        end
      end
    end
    bus_ack_i = 1'b0;
    bus_err_i = 1'b0;
    exp_cyc = !e_bus ? 0 : ((mode == 2) ? TMO : dly + 1);
    exp_t   = !e_bus ? 1 : ((mode == 2) ? TMO + 1 : dly + 2);
    check_val({name, "_rsp_time"}, t_rsp, exp_t);
    check_val({name, "_cyc_cycles"}, cyc_cnt, exp_cyc);
    check_val({name, "_stall"}, ready_bad, 0);
    if (e_bus) begin
      check_val({name, "_bus_stable"}, unstable, 0);
      check_val({name, "_adr"}, s_adr, e_adr);
      check_val({name, "_sel"}, s_sel, e_sel);
      check_val({name, "_we"}, s_we, e_we);
      if (e_we) check_val({name, "_wdat"}, s_dat, e_dat);
    end
    check_val({name, "_exc"}, exc_o, e_exc);
    check_val({name, "_cause"}, exc_cause_o, e_cause);
    check_val({name, "_sp_write"}, sp_write_o, e_spw);
    if (e_spw) check_val({name, "_sp_data"}, sp_data_o, e_spd);
    if (e_chk_rd) check_val({name, "_rdata"}, rdata_o, e_rdata);
    @(negedge clk_i);
    check_val({name, "_rsp_pulse"}, rsp_valid_o, 0);
    check_val({name, "_ready_after"}, req_ready_o, 1);
    check_val({name, "_cause_hold"}, exc_cause_o, e_cause);
  endtask

  initial begin
    int rsp_seen, cyc_seen, r, mode;
    logic [1:0]  sz;
    logic [31:0] ad, sp;

    // Reset state
    #12;
    check_val("rst_ready", req_ready_o, 1);
    check_val("rst_rsp_valid", rsp_valid_o, 0);
    check_val("rst_cyc", bus_cyc_o, 0);
    check_val("rst_sel", bus_sel_o, 0);
    check_val("rst_exc", exc_o, 0);
    check_val("rst_rdata", rdata_o, 0);
    check_val("rst_sp_write", sp_write_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed cases
    do_req("ldb_signed", 3'd1, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h0, 0, 0, 32'h0000_00F0);
    do_req("sth_slow", 3'd2, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 32'h0, 0, 5, 32'h0);
    do_req("push", 3'd3, 2'd0, 1'b0, 32'h0, 32'h1234_5678, 32'h8000, 0, 1, 32'h0);
    do_req("pop", 3'd4, 2'd0, 1'b0, 32'h0, 32'h0, 32'h7FFC, 0, 2, 32'hCAFE_F00D);
    do_req("ldw_misal", 3'd1, 2'd2, 1'b0, 32'h1001, 32'h0, 32'h0, 0, 0, 32'h0);
    do_req("ld_size3", 3'd1, 2'd3, 1'b0, 32'h1000, 32'h0, 32'h0, 0, 0, 32'h0);
    do_req("timeout", 3'd1, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 2, 0, 32'h0);
    do_req("ack_err", 3'd1, 2'd2, 1'b0, 32'h4004, 32'h0, 32'h0, 3, 1, 32'h1111_2222);
    do_req("bus_err", 3'd3, 2'd0, 1'b0, 32'h0, 32'h5555, 32'h100, 1, 0, 32'h0);
    do_req("op_none", 3'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    do_req("push_wrap", 3'd3, 2'd0, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 0, 32'h0);
    do_req("pop_wrap", 3'd4, 2'd0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 0, 0, 32'h8765_4321);
    do_req("ldh_signed", 3'd1, 2'd1, 1'b1, 32'h3000, 32'h0, 32'h0, 0, 0, 32'h8001_7777);
    do_req("ldh_zero", 3'd1, 2'd1, 1'b0, 32'h3000, 32'h0, 32'h0, 0, 0, 32'h8001_7777);
    do_req("stb_lane0", 3'd2, 2'd0, 1'b0, 32'h3000, 32'h0000_00A5, 32'h0, 0, 0, 32'h0);

    // Randomized requests
    for (int i = 0; i < 80; i++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      sp = $urandom;
      if ($urandom_range(0, 4) != 0) sp = sp & ~32'd3;
      r = $urandom_range(0, 9);
      mode = (r < 7) ? 0 : r - 6;
      do_req("rand", 3'($urandom_range(0, 4)), sz, 1'($urandom_range(0, 1)), ad, $urandom, sp,
             mode, $urandom_range(0, 6), $urandom);
    end

    // Reset while a bus cycle is open
    @(negedge clk_i);
    req_valid_i = 1'b1; op_i = 3'd1; size_i = 2'd2; addr_i = 32'h5000;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0; op_i = 3'd0;
    @(negedge clk_i);
    check_val("midrst_cyc_before", bus_cyc_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check_val("midrst_cyc_async", bus_cyc_o, 0);
    rsp_seen = 0;
    cyc_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (i == 2) rst_i = 1'b0;
      if (rsp_valid_o) rsp_seen++;
      if (bus_cyc_o) cyc_seen++;
    end
    check_val("midrst_no_rsp", rsp_seen, 0);
    check_val("midrst_no_cyc", cyc_seen, 0);
    check_val("midrst_ready", req_ready_o, 1);
    do_req("post_rst", 3'd1, 2'd2, 1'b0, 32'h6000, 32'h0, 32'h0, 0, 0, 32'h0BAD_CAFE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
